// File: rtl/riscv_cache_pkg.sv
// Shared cache geometry helpers: set count and address field widths
// derived from cache size, line size and associativity.
package riscv_cache_pkg;

   // Number of sets for a cache of cache_size KBytes with block_size-bit lines.
   function automatic int no_of_sets(input int cache_size, input int block_size, input int ways);
      return (cache_size * 1024 * 8) / block_size / ways;
   endfunction

   // Byte-offset bits inside one cache line.
   function automatic int no_of_block_offset_bits(input int block_size);
      return $clog2(block_size / 8);
   endfunction

   // Set-index bits.
   function automatic int no_of_index_bits(input int sets);
      return $clog2(sets);
   endfunction

   // Word-in-line offset bits. A single-word line would need zero bits;
   // a one-bit field (always driven to zero by the owner) keeps the ports legal.
   function automatic int no_of_data_offset_bits(input int block_size, input int xlen);
      int bits;
      bits = no_of_block_offset_bits(block_size) - $clog2(xlen / 8);
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/riscv_cache_wbuf.sv
// Cache data-memory write buffer.
// Store hits are queued in a small circular FIFO and retired in push order
// whenever the address-setup stage leaves the shared memory port idle. When
// the buffer is full it takes the port anyway and blocks the read. Pending
// indices are compared against the setup-stage lookup to flag read hazards.
//
// Handshake: a store is taken at a rising edge when wreq_i=1 and either
// full_o=0 or mem_we_o=1 (a drain frees a slot in the same edge). Upstream
// must hold off on full_o; wreq_i while full without a drain is illegal.
// An entry retires at the rising edge where mem_we_o=1.
module riscv_cache_wbuf
   import riscv_cache_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SIZE       = 64,
   parameter int BLOCK_SIZE = XLEN,
   parameter int WAYS       = 2,
   parameter int DEPTH      = 4,
   localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
   localparam int IDX_BITS      = no_of_index_bits(SETS),
   localparam int DAT_OFFS_BITS = no_of_data_offset_bits(BLOCK_SIZE, XLEN),
   localparam int WAY_BITS      = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int BE_BITS       = XLEN / 8
) (
   input  logic                     rst_ni,
   input  logic                     clk_i,
   input  logic                     wreq_i,
   input  logic [IDX_BITS-1:0]      widx_i,
   input  logic [WAY_BITS-1:0]      wway_i,
   input  logic [DAT_OFFS_BITS-1:0] woffs_i,
   input  logic [BE_BITS-1:0]       wbe_i,
   input  logic [XLEN-1:0]          wdata_i,
   input  logic                     rreq_i,
   input  logic [IDX_BITS-1:0]      lookup_idx_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     hazard_o,
   output logic                     rd_block_o,
   output logic                     mem_we_o,
   output logic [IDX_BITS-1:0]      mem_idx_o,
   output logic [WAY_BITS-1:0]      mem_way_o,
   output logic [DAT_OFFS_BITS-1:0] mem_offs_o,
   output logic [BE_BITS-1:0]       mem_be_o,
   output logic [XLEN-1:0]          mem_d_o
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   typedef struct packed {
      logic [IDX_BITS-1:0]      idx;
      logic [WAY_BITS-1:0]      way;
      logic [DAT_OFFS_BITS-1:0] offs;
      logic [BE_BITS-1:0]       be;
      logic [XLEN-1:0]          data;
   } entry_t;

   entry_t              entry_q [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [CNT_BITS-1:0] count;
   logic                push;
   logic                pop;
   entry_t              head;

   // Status flags come straight from the count register, so wreq_i never
   // reaches full_o/empty_o combinationally.
   assign full_o  = (count == CNT_BITS'(DEPTH));
   assign empty_o = (count == '0);

   // Retire whenever the port is free, or unconditionally when full.
   assign mem_we_o   = !empty_o && (!rreq_i || full_o);
   assign rd_block_o = full_o && rreq_i && !empty_o;

   assign pop  = mem_we_o;
   assign push = wreq_i && (!full_o || mem_we_o);

   assign head       = entry_q[rd_ptr];
   assign mem_idx_o  = head.idx;
   assign mem_way_o  = head.way;
   assign mem_offs_o = head.offs;
   assign mem_be_o   = head.be;
   assign mem_d_o    = head.data;

   // Pointer, count and valid-bit bookkeeping; a push into the slot being
   // popped (only possible when full) leaves that slot valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid_q <= '0;
      end else begin
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_BITS'(1);
         end
         if (push) begin
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_BITS'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage; not reset, contents only matter once valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         entry_q[wr_ptr] <= '{idx: widx_i, way: wway_i, offs: woffs_i,
                              be: wbe_i, data: wdata_i};
      end
   end

   // Hazard: any pending entry (including the one draining now) whose set
   // index matches the lookup. Way is ignored because a read fetches all ways.
   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i].idx == lookup_idx_i)) begin
            hazard_o = 1'b1;
         end
      end
   end

   // Upstream must stall on full_o unless a drain happens in the same cycle.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(wreq_i && full_o && !mem_we_o));

endmodule

// File: tb/tb_riscv_cache_wbuf.sv
// Self-checking bench for riscv_cache_wbuf, with a queue-based reference model.
module tb_riscv_cache_wbuf;

   localparam int XLEN       = 32;
   localparam int SIZE       = 64;
   localparam int BLOCK_SIZE = 128;
   localparam int WAYS       = 2;
   localparam int DEPTH      = 4;
   // 64 KB / 16-byte lines / 2 ways = 2048 sets -> 11 index bits;
   // 16-byte line of 4-byte words -> 2 word-offset bits.
   localparam int IW = 11;
   localparam int OW = 2;
   localparam int EW = IW + 1 + OW + 4 + XLEN;

   logic          rst_ni;
   logic          clk_i;
   logic          wreq_i;
   logic [IW-1:0] widx_i;
   logic          wway_i;
   logic [OW-1:0] woffs_i;
   logic [3:0]    wbe_i;
   logic [31:0]   wdata_i;
   logic          rreq_i;
   logic [IW-1:0] lookup_idx_i;
   logic          full_o;
   logic          empty_o;
   logic          hazard_o;
   logic          rd_block_o;
   logic          mem_we_o;
   logic [IW-1:0] mem_idx_o;
   logic          mem_way_o;
   logic [OW-1:0] mem_offs_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_d_o;

   logic [EW-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   riscv_cache_wbuf #(
      .XLEN(XLEN), .SIZE(SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS), .DEPTH(DEPTH)
   ) dut (
      .rst_ni(rst_ni), .clk_i(clk_i), .wreq_i(wreq_i), .widx_i(widx_i),
      .wway_i(wway_i), .woffs_i(woffs_i), .wbe_i(wbe_i), .wdata_i(wdata_i),
      .rreq_i(rreq_i), .lookup_idx_i(lookup_idx_i), .full_o(full_o),
      .empty_o(empty_o), .hazard_o(hazard_o), .rd_block_o(rd_block_o),
      .mem_we_o(mem_we_o), .mem_idx_o(mem_idx_o), .mem_way_o(mem_way_o),
      .mem_offs_o(mem_offs_o), .mem_be_o(mem_be_o), .mem_d_o(mem_d_o)
   );

   // Clock: 10 time-unit period.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model at the
   // falling edge, then advance the model across the rising edge.
   task automatic cycle(input logic w, input logic [IW-1:0] idx, input logic way,
                        input logic [OW-1:0] offs, input logic [3:0] be,
                        input logic [31:0] d, input logic r, input logic [IW-1:0] lk);
      int   n;
      logic exp_we;
      logic exp_hz;
      wreq_i = w; widx_i = idx; wway_i = way; woffs_i = offs; wbe_i = be;
      wdata_i = d; rreq_i = r; lookup_idx_i = lk;
      @(negedge clk_i);
      n      = exp_q.size();
      exp_we = (n > 0) && (!r || n == DEPTH);
      exp_hz = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][EW-1 -: IW] == lk) exp_hz = 1'b1;
      check("full",     64'(full_o),     64'(n == DEPTH));
      check("empty",    64'(empty_o),    64'(n == 0));
      check("mem_we",   64'(mem_we_o),   64'(exp_we));
      check("rd_block", 64'(rd_block_o), 64'(n == DEPTH && r));
      check("hazard",   64'(hazard_o),   64'(exp_hz));
      check("count",    64'(dut.count),  64'(n));
      if (exp_we)
         check("retire_payload",
               64'({mem_idx_o, mem_way_o, mem_offs_o, mem_be_o, mem_d_o}), 64'(exp_q[0]));
      @(posedge clk_i);
      if (exp_we) void'(exp_q.pop_front());
      if (w && (n < DEPTH || exp_we)) exp_q.push_back({idx, way, offs, be, d});
      #1;
   endtask

   task automatic idle(input logic r);
      cycle(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, r, 11'h7FF);
   endtask

   task automatic drain_all();
      for (int i = 0; i < 3 * DEPTH && exp_q.size() > 0; i++) idle(1'b0);
      check("drained", 64'(empty_o), 64'(1));
   endtask

   initial begin
      wreq_i = 0; widx_i = '0; wway_i = 0; woffs_i = '0; wbe_i = '0; wdata_i = '0;
      rreq_i = 0; lookup_idx_i = '0;
      rst_ni = 1'b0;
      #12;
      check("rst_empty",  64'(empty_o),    64'(1));
      check("rst_full",   64'(full_o),     64'(0));
      check("rst_we",     64'(mem_we_o),   64'(0));
      check("rst_hazard", 64'(hazard_o),   64'(0));
      check("rst_block",  64'(rd_block_o), 64'(0));
      @(negedge clk_i); rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Idle drain of a single store.
      cycle(1'b1, 11'd5, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, 11'd0);
      idle(1'b0);
      idle(1'b0);

      // Reads hold off retirement; release drains in push order.
      cycle(1'b1, 11'd1, 1'b0, 2'd0, 4'h3, 32'h11111111, 1'b1, 11'd0);
      cycle(1'b1, 11'd2, 1'b1, 2'd1, 4'hC, 32'h22222222, 1'b1, 11'd0);
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      // Fill under read pressure, forced drain plus push while full.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, IW'(16 + i), 1'(i), OW'(i), 4'h1 << (i % 4), 32'hA0000000 + i, 1'b1, 11'd0);
      cycle(1'b1, 11'd30, 1'b0, 2'd3, 4'h9, 32'hCAFEF00D, 1'b1, 11'd0);
      idle(1'b1);
      drain_all();

      // Hazard on a matching index; none on a different one.
      cycle(1'b1, 11'd9, 1'b0, 2'd0, 4'hF, 32'h99999999, 1'b1, 11'd9);
      cycle(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 11'd9);
      cycle(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 11'd8);
      cycle(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, 1'b0, 11'd9);
      cycle(1'b0, '0, 1'b0, '0, 4'h0, 32'h0, 1'b0, 11'd9);
      check("hazard_cleared", 64'(hazard_o), 64'(0));

      // Randomized streaming with wrap-around and random read pressure.
      for (int i = 0; i < 80; i++)
         cycle(1'($urandom_range(0, 3) != 0), IW'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), OW'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 2) == 0),
               IW'($urandom_range(0, 7)));
      drain_all();

      // Reset mid-stream with three pending entries.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, IW'(40 + i), 1'b0, 2'd0, 4'hF, 32'h5000 + i, 1'b1, 11'd40);
      wreq_i = 1'b0; rreq_i = 1'b0;
      #1;
      check("pre_rst_we", 64'(mem_we_o), 64'(1));
      rst_ni = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_empty",  64'(empty_o),  64'(1));
      check("midrst_we",     64'(mem_we_o), 64'(0));
      check("midrst_hazard", 64'(hazard_o), 64'(0));
      @(negedge clk_i); rst_ni = 1'b1;
      @(posedge clk_i); #1;
      for (int i = 0; i < 4; i++) idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
